// File: rtl/vga_scanout_scheduler.sv
// VGA 640x480 scan-out scheduler: timing counters, frame-buffer read
// address one cycle ahead of the pixel, and vblank-aligned buffer swap.
module vga_scanout_scheduler #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int PIX_W    = 19
) (
    input  logic             clk_vga,
    input  logic             reset_n,
    input  logic             i_swap_req,
    output logic             o_swap_ack,
    output logic             o_display_sel,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_active,
    output logic             o_rd_en,
    output logic [PIX_W:0]   o_rd_addr,
    output logic             o_frame_start,
    output logic             o_vblank
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_FETCH_LO = HW'(H_SYNC + H_BACK - 1);
    localparam logic [HW-1:0] H_FETCH_HI = HW'(H_SYNC + H_BACK + H_ACTIVE - 2);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [VW-1:0] V_BLK_BEG  = VW'(V_SYNC + V_BACK + V_ACTIVE);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } state_t;

    logic [HW-1:0]    r_hcnt;
    logic [VW-1:0]    r_vcnt;
    logic [PIX_W-1:0] r_pix;
    logic             r_active;
    logic             r_frame_start;
    logic             r_req_s1;
    logic             r_req_s2;
    logic             r_display_sel;
    state_t           r_state;
    state_t           w_state_nxt;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_v_act;
    logic w_fetch;
    logic w_vb_start;
    logic w_toggle;
    logic w_ack;

    assign w_h_wrap   = (r_hcnt == H_LAST);
    assign w_v_wrap   = (r_vcnt == V_LAST);
    assign w_v_act    = (r_vcnt >= V_ACT_LO) && (r_vcnt <= V_ACT_HI);
    assign w_fetch    = w_v_act && (r_hcnt >= H_FETCH_LO)
                        && (r_hcnt <= H_FETCH_HI);
    assign w_vb_start = (r_hcnt == '0) && (r_vcnt == V_BLK_BEG);

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_wrap ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // Frame-start pulse is registered so it is 0 out of reset even though
    // the counters sit at (0,0).
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix         <= '0;
        end else begin
            r_active      <= w_fetch;
            r_frame_start <= w_h_wrap && w_v_wrap;
            if (r_frame_start)
                r_pix <= '0;
            else if (w_fetch)
                r_pix <= (r_pix == PIX_LAST) ? '0 : r_pix + PIX_W'(1);
        end
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
        end else begin
            r_req_s1 <= i_swap_req;
            r_req_s2 <= r_req_s1;
        end
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (r_req_s2)   w_state_nxt = PENDING;
            PENDING: if (w_vb_start) w_state_nxt = ACK;
            ACK:     if (!r_req_s2)  w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_toggle = (r_state == PENDING) && w_vb_start;
        w_ack    = (r_state == ACK);
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n)
            r_display_sel <= 1'b0;
        else if (w_toggle)
            r_display_sel <= ~r_display_sel;
    end

    assign o_swap_ack    = w_ack;
    assign o_display_sel = r_display_sel;
    assign o_hs          = (r_hcnt >= H_SYNC_END);
    assign o_vs          = (r_vcnt >= V_SYNC_END);
    assign o_vblank      = !w_v_act;
    assign o_rd_en       = w_fetch;
    assign o_active      = r_active;
    assign o_frame_start = r_frame_start;
    assign o_rd_addr     = {r_display_sel, r_pix};

endmodule

// File: tb/tb_vga_scanout_scheduler.sv
// Scoreboard bench for vga_scanout_scheduler on a shrunken 17x11 raster
// (8x4 active pixels) so many frames and swaps fit in a short run.
module tb_vga_scanout_scheduler;

    localparam int PIX_W = 19;
    localparam int HT    = 17;
    localparam int VT    = 11;
    localparam int FT    = HT * VT;

    logic             clk_vga = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_swap_req = 1'b0;
    logic             o_swap_ack;
    logic             o_display_sel;
    logic             o_hs;
    logic             o_vs;
    logic             o_active;
    logic             o_rd_en;
    logic [PIX_W:0]   o_rd_addr;
    logic             o_frame_start;
    logic             o_vblank;

    vga_scanout_scheduler #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(4), .V_FRONT(2),
        .PIX_W(PIX_W)
    ) dut (
        .clk_vga(clk_vga),
        .reset_n(reset_n),
        .i_swap_req(i_swap_req),
        .o_swap_ack(o_swap_ack),
        .o_display_sel(o_display_sel),
        .o_hs(o_hs),
        .o_vs(o_vs),
        .o_active(o_active),
        .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr),
        .o_frame_start(o_frame_start),
        .o_vblank(o_vblank)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int   cyc;
        logic sel;
    } ev_t;

    int             c;
    int             checks = 0;
    int             errors = 0;
    logic [PIX_W:0] q_addr[$];
    ev_t            q_rise[$];
    int             q_fall[$];
    logic           prev_ack;

    always @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) c <= 0;
        else          c <= c + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s c=%0d got=%0h exp=%0h", name, c, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s c=%0d got=event exp=none", name, c);
    endtask

    function automatic logic fetch(input int k);
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        return (v >= 5) && (v <= 8) && (h >= 6) && (h <= 13);
    endfunction

    task automatic push_frame(input logic s);
        for (int i = 0; i < 32; i++)
            q_addr.push_back({s, PIX_W'(i)});
    endtask

    task automatic wait_c(input int n);
        while (c < n) @(negedge clk_vga);
    endtask

    task automatic check_reset_vals();
        chk("rst_hs", o_hs, 0);
        chk("rst_vs", o_vs, 0);
        chk("rst_vblank", o_vblank, 1);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_active", o_active, 0);
        chk("rst_frame_start", o_frame_start, 0);
        chk("rst_ack", o_swap_ack, 0);
        chk("rst_sel", o_display_sel, 0);
        chk("rst_addr", o_rd_addr, 0);
    endtask

    always @(negedge clk_vga) begin
        int h, v;
        ev_t ev;
        if (!reset_n) begin
            prev_ack <= 1'b0;
        end else begin
            h = c % HT;
            v = (c / HT) % VT;
            chk("hs", o_hs, h >= 4);
            chk("vs", o_vs, v >= 2);
            chk("vblank", o_vblank, !((v >= 5) && (v <= 8)));
            chk("rd_en", o_rd_en, fetch(c));
            chk("active", o_active, (c > 0) && fetch(c - 1));
            chk("frame_start", o_frame_start, (c > 0) && (c % FT == 0));
            if (o_rd_en) begin
                if (q_addr.size() == 0) unexpected("rd_addr");
                else chk("rd_addr", o_rd_addr, q_addr.pop_front());
            end
            if (o_swap_ack && !prev_ack) begin
                if (q_rise.size() == 0) begin
                    unexpected("ack_rise");
                end else begin
                    ev = q_rise.pop_front();
                    chk("ack_rise_cyc", c, ev.cyc);
                    chk("sel_after_swap", o_display_sel, ev.sel);
                end
            end
            if (!o_swap_ack && prev_ack) begin
                if (q_fall.size() == 0) unexpected("ack_fall");
                else chk("ack_fall_cyc", c, q_fall.pop_front());
            end
            prev_ack <= o_swap_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog c=%0d got=timeout exp=finish", c);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        i_swap_req = 1'b0;
        repeat (3) @(negedge clk_vga);
        #1 check_reset_vals();
        @(negedge clk_vga);
        #2 reset_n = 1'b1;

        // Epoch 0: swap requested mid-active in frame 2, held past frame 3
        // vblank, then a reset lands while a second swap is pending.
        for (int f = 0; f < 3; f++) push_frame(1'b0);
        push_frame(1'b1);
        push_frame(1'b1);
        q_rise.push_back('{528, 1'b1});
        q_fall.push_back(733);

        wait_c(479); i_swap_req = 1'b1;
        wait_c(730); i_swap_req = 1'b0;
        wait_c(836); i_swap_req = 1'b1;
        wait_c(842);
        #2 reset_n = 1'b0;
        #1 check_reset_vals();
        chk("events_before_reset", q_rise.size() + q_fall.size(), 0);
        q_addr.delete();
        q_rise.delete();
        q_fall.delete();
        repeat (2) @(negedge clk_vga);
        #1 check_reset_vals();
        #1 reset_n = 1'b1;

        // Epoch 1: held request re-detected, then a request raised inside
        // vblank must wait for the following frame's vblank start.
        push_frame(1'b0);
        push_frame(1'b1);
        push_frame(1'b1);
        push_frame(1'b0);
        q_rise.push_back('{154, 1'b1});
        q_rise.push_back('{528, 1'b0});
        q_fall.push_back(203);
        q_fall.push_back(583);

        wait_c(200); i_swap_req = 1'b0;
        wait_c(359); i_swap_req = 1'b1;
        wait_c(580); i_swap_req = 1'b0;
        wait_c(760);
        #1;
        chk("addr_queue_left", q_addr.size(), 0);
        chk("rise_queue_left", q_rise.size(), 0);
        chk("fall_queue_left", q_fall.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scanout_scheduler.md
# vga_scanout_scheduler

Sequences display scan-out of the double-buffered 8-bit frame buffer in the `clk_vga` domain. It owns the 640x480 VGA timing counters and generates the per-pixel read enable and address for frame-buffer port B, one cycle ahead of the pixel to cover the 1-cycle block-RAM read latency. It also arbitrates the render side's buffer-swap request so the front/back buffer exchange happens only at the start of vertical blanking, never mid-frame.

## Interface
Parameters:
- `H_SYNC`, default 96: horizontal sync pulse width, in pixels.
- `H_BACK`, default 48: horizontal back porch.
- `H_ACTIVE`, default 640: horizontal active pixels.
- `H_FRONT`, default 16: horizontal front porch. The line period is the sum of the four, 800.
- `V_SYNC`, default 2: vertical sync pulse width, in lines.
- `V_BACK`, default 33: vertical back porch.
- `V_ACTIVE`, default 480: active lines.
- `V_FRONT`, default 10: vertical front porch. The frame period is 525 lines.
- `PIX_W`, default 19: width of the pixel index.

Ports:
- `clk_vga`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_swap_req`  in  1  level request from the render domain, 4-phase handshake; synchronized internally with 2 flops.
- `o_swap_ack`  out  1  4-phase acknowledge; a synchronizer is the consumer's responsibility.
- `o_display_sel`  out  1  buffer currently scanned out; the render side writes the other buffer.
- `o_hs`  out  1  horizontal sync, active low.
- `o_vs`  out  1  vertical sync, active low.
- `o_active`  out  1  pixel data on RAM `doutb` is valid this cycle.
- `o_rd_en`  out  1  frame-buffer read enable.
- `o_rd_addr`  out  PIX_W+1  `{o_display_sel, pixel index}`.
- `o_frame_start`  out  1  1-cycle pulse at `hcnt==0 && vcnt==0`.
- `o_vblank`  out  1  high while `vcnt` is outside the active lines.

## Operation
- Counters:
  - `hcnt` counts 0..799 and wraps to 0.
  - `vcnt` increments synchronously when `hcnt` wraps, counts 0..524 and wraps to 0.
  - Both are clocked only by `clk_vga`; no derived clocks.
- Sync decodes:
  - `o_hs` = 0 iff `hcnt < 96`.
  - `o_vs` = 0 iff `vcnt < 2`.
- Active window: `hcnt` in [144,783] and `vcnt` in [35,514], exactly 640x480 pixels.
- Fetch window: `hcnt` in [143,782] with the same `vcnt` range. `o_rd_en` is high exactly in the fetch window.
- `o_active` is `o_rd_en` delayed by one cycle.
- Pixel index:
  - Incrementing counter; no multiplier.
  - Cleared to 0 on `o_frame_start`.
  - Increments after each cycle with `o_rd_en` high.
  - Runs 0..307199 per frame and must not exceed 307199.
- Swap FSM, states `IDLE`, `PENDING`, `ACK`:
  - `IDLE`: on synchronized req = 1, go to `PENDING`.
  - `PENDING`: on `hcnt==0 && vcnt==515` (vblank start), toggle `o_display_sel`, set `o_swap_ack`=1, go to `ACK`.
  - `ACK`: on synchronized req = 0, clear `o_swap_ack` and go to `IDLE`.
- A request arriving during vblank waits for the next frame's vblank start; at most one swap per frame.
- `o_display_sel` changes only at vblank start, so `o_rd_addr[PIX_W]` is constant across every active region.

## Timing
- Reset values:
  - `hcnt`, `vcnt`, pixel index, `o_swap_ack`, `o_display_sel`, `o_rd_en`, `o_active`, `o_frame_start` all 0.
  - FSM in `IDLE`; synchronizer flops 0.
  - `o_hs`=0 and `o_vs`=0, since the counters are 0.
  - `o_vblank`=1.
- After reset release, the first edge advances `hcnt` to 1. `o_frame_start` next pulses 420000 cycles later.
- Read latency: address presented in cycle t; pixel valid when `o_active` is high in cycle t+1.
- Swap latency: 2 cycles of synchronizer plus the wait for vblank start. Worst case is about 1 frame plus 2 cycles.
- Reset mid-operation:
  - Any pending swap is dropped. A requester holding req high is re-detected after release.
  - `o_display_sel` returns to 0.
- Simultaneous events: if req deasserts in the same cycle `PENDING` reaches vblank start, the swap still completes. Ack then drops after the synchronizer delay.
- All outputs are registered or decoded directly from registers; no combinational path exists from `i_swap_req`.

## Test plan
- Reset, then run 2 frames:
  - `o_hs` is low 96 of every 800 cycles.
  - `o_vs` is low for 1600 cycles per 420000.
  - `o_frame_start` pulses every 420000 cycles.
- Active-region address sweep:
  - First `o_rd_en` at `vcnt`=35, `hcnt`=143 with `o_rd_addr`=0.
  - Last at `vcnt`=514, `hcnt`=782 with `o_rd_addr`=307199.
  - 307200 enables per frame; `o_active` lags `o_rd_en` by exactly 1 cycle.
- Swap request raised at `vcnt`=100:
  - `o_display_sel` toggles and `o_swap_ack` rises on the cycle after `vcnt`=515, `hcnt`=0.
  - `o_rd_addr[19]`=1 throughout the next active region.
- Request raised at `vcnt`=520 (inside vblank): swap occurs at the next frame's `vcnt`=515, not earlier.
- Req held high through ack: no second swap occurs. Then drop req: `o_swap_ack` falls within 3 cycles and the FSM returns to `IDLE`.
- Assert `reset_n`=0 mid-line in `PENDING` state:
  - All outputs hold reset values immediately (asynchronous reset).
  - After release with req still high, a swap occurs at the next vblank start.
